// File: rtl/smu_pwr_seq.sv
// Per-bank low-power sequencer for the SMU SRAM banks: idle-driven clock gating, retention entry,
// and wake-up with an AHB hready stall until the bank is usable again.
module smu_pwr_seq #(
  parameter int NBANK    = 4,
  parameter int CNT_W    = 16,
  parameter int RET_DLY  = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic                 pmu_smc_hclk,
  input  logic                 pmu_smc_hrst_b,
  input  logic [NBANK-1:0]     sms_idle,
  input  logic [NBANK-1:0]     bank_hsel,
  input  logic [NBANK-1:0]     bank_htrans1,
  input  logic [NBANK-1:0]     sleep_en,
  input  logic [NBANK-1:0]     ret_en,
  input  logic [CNT_W-1:0]     idle_thresh,
  output logic [NBANK-1:0]     bank_clk_en,
  output logic [NBANK-1:0]     bank_ret,
  output logic [NBANK-1:0]     bank_hold,
  output logic [2*NBANK-1:0]   bank_state,
  output logic                 all_ret
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,
    ST_CG     = 2'b01,
    ST_RET    = 2'b10,
    ST_WAKE   = 2'b11
  } state_t;

  localparam logic [CNT_W:0] RET_DLY_C  = (CNT_W+1)'(RET_DLY);
  localparam logic [CNT_W:0] WAKE_CYC_C = (CNT_W+1)'(WAKE_CYC);

  logic [NBANK-1:0] req;
  logic [NBANK-1:0] qualify;
  logic             thresh_nz;

  assign req       = bank_hsel & bank_htrans1;
  assign thresh_nz = |idle_thresh;
  assign qualify   = sms_idle & ~req & sleep_en & {NBANK{thresh_nz}};

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so threshold compares never alias on counter wrap.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_ff @(posedge pmu_smc_hclk or negedge pmu_smc_hrst_b) begin
      if (!pmu_smc_hrst_b) begin
        state_q <= ST_ACTIVE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_ACTIVE: begin
            if (!qualify[i]) begin
              cnt_q <= '0;
            end else if (cnt_inc == {1'b0, idle_thresh}) begin
              state_q <= ST_CG;
              cnt_q   <= '0;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_inc[CNT_W-1:0];
            end
          end
          ST_CG: begin
            if (req[i] || !sleep_en[i]) begin
              state_q <= ST_WAKE;
              cnt_q   <= '0;
            end else if (ret_en[i]) begin
              if (cnt_inc == RET_DLY_C) begin
                state_q <= ST_RET;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc[CNT_W-1:0];
              end
            end
          end
          ST_RET: begin
            if (req[i] || !sleep_en[i]) begin
              state_q <= ST_WAKE;
              cnt_q   <= '0;
            end
          end
          ST_WAKE: begin
            if (cnt_inc == WAKE_CYC_C) begin
              state_q <= ST_ACTIVE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc[CNT_W-1:0];
            end
          end
        endcase
      end
    end

    assign bank_state[2*i +: 2] = state_q;
    assign bank_clk_en[i]       = (state_q == ST_ACTIVE) || (state_q == ST_WAKE);
    assign bank_ret[i]          = (state_q == ST_RET);
    // The request cycle itself is stalled so the master never samples a gated bank.
    assign bank_hold[i]         = (state_q == ST_WAKE) ||
                                  (((state_q == ST_CG) || (state_q == ST_RET)) && req[i]);
  end

  assign all_ret = &bank_ret;

endmodule

// File: tb/tb_smu_pwr_seq.sv
// Self-checking bench for smu_pwr_seq: per-cycle scoreboard against a behavioural bank model,
// plus directed latency checks for CG/RET entry, wake stall length and reset abort.
module tb_smu_pwr_seq;
  localparam int NB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NB-1:0]   sms_idle, bank_hsel, bank_htrans1, sleep_en, ret_en;
  logic [15:0]     idle_thresh;
  logic [NB-1:0]   bank_clk_en, bank_ret, bank_hold;
  logic [2*NB-1:0] bank_state;
  logic            all_ret;

  smu_pwr_seq dut (
    .pmu_smc_hclk  (clk),
    .pmu_smc_hrst_b(rst_n),
    .sms_idle      (sms_idle),
    .bank_hsel     (bank_hsel),
    .bank_htrans1  (bank_htrans1),
    .sleep_en      (sleep_en),
    .ret_en        (ret_en),
    .idle_thresh   (idle_thresh),
    .bank_clk_en   (bank_clk_en),
    .bank_ret      (bank_ret),
    .bank_hold     (bank_hold),
    .bank_state    (bank_state),
    .all_ret       (all_ret)
  );

  // scoreboard
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs;
  int          m_st[NB];
  int          m_cnt[NB];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Packing: state[7:0], clk_en[11:8], ret[15:12], hold[19:16], all_ret[20]
  function automatic logic [31:0] dut_vec();
    return {11'd0, all_ret, bank_hold, bank_ret, bank_clk_en, bank_state};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [7:0] st;
    logic [3:0] ce, rt, hd;
    logic       ar;
    bit         rq;
    ar = 1'b1;
    for (int i = 0; i < NB; i++) begin
      rq = bank_hsel[i] && bank_htrans1[i];
      st[2*i +: 2] = 2'(m_st[i]);
      ce[i] = (m_st[i] == 0) || (m_st[i] == 3);
      rt[i] = (m_st[i] == 2);
      hd[i] = (m_st[i] == 3) || (rq && (m_st[i] == 1 || m_st[i] == 2));
      if (m_st[i] != 2) ar = 1'b0;
    end
    return {11'd0, ar, hd, rt, ce, st};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_st[i]  = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    bit rq, q;
    for (int i = 0; i < NB; i++) begin
      rq = bank_hsel[i] && bank_htrans1[i];
      q  = sms_idle[i] && !rq && sleep_en[i] && (idle_thresh != 0);
      if (m_st[i] == 0) begin
        if (!q) m_cnt[i] = 0;
        else if (m_cnt[i] + 1 == int'(idle_thresh)) begin m_st[i] = 1; m_cnt[i] = 0; end
        else if (m_cnt[i] < 65535) m_cnt[i]++;
      end else if (m_st[i] == 1) begin
        if (rq || !sleep_en[i]) begin m_st[i] = 3; m_cnt[i] = 0; end
        else if (ret_en[i] && m_cnt[i] + 1 == 16) begin m_st[i] = 2; m_cnt[i] = 0; end
        else if (ret_en[i]) m_cnt[i]++;
      end else if (m_st[i] == 2) begin
        if (rq || !sleep_en[i]) begin m_st[i] = 3; m_cnt[i] = 0; end
      end else begin
        if (m_cnt[i] + 1 == 2) begin m_st[i] = 0; m_cnt[i] = 0; end
        else m_cnt[i]++;
      end
    end
  endtask

  // driver: one clock of stimulus; outputs compared before the edge, model advanced across it
  task automatic run_cycle(input logic [3:0] idl, input logic [3:0] hs, input logic [3:0] ht,
                           input logic [3:0] slp, input logic [3:0] ret, input logic [15:0] th);
    sms_idle = idl; bank_hsel = hs; bank_htrans1 = ht;
    sleep_en = slp; ret_en = ret; idle_thresh = th;
    #1;
    if (!rst_n) model_reset();
    exp_q.push_back(model_vec());
    obs = dut_vec();
    check_val("cycle", obs, exp_q.pop_front());
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  function automatic logic [3:0] rbits(input int pct);
    logic [3:0] r;
    for (int i = 0; i < NB; i++) r[i] = ($urandom_range(99) < pct);
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) run_cycle(rbits(50), rbits(50), rbits(50), rbits(50), rbits(50), 16'($urandom_range(15)));
    rst_n = 1'b1;
  endtask

  int n, h;

  initial begin
    rst_n = 1'b0;
    sms_idle = '0; bank_hsel = '0; bank_htrans1 = '0;
    sleep_en = '0; ret_en = '0; idle_thresh = '0;
    model_reset();
    @(negedge clk);

    // reset with toggling inputs
    do_reset();
    rst_n = 1'b0;
    run_cycle(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 16'd1);
    check_val("rst_outputs", dut_vec(), 32'h0000_0F00);
    rst_n = 1'b1;

    // bank0 idle: CG after 8 cycles, RET 16 cycles later
    do_reset();
    n = 0;
    for (int k = 0; k < 100; k++) begin
      run_cycle(4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 16'd8);
      n++;
      if (bank_state[1:0] == 2'b01) break;
    end
    check_val("cg_latency", n, 8);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      run_cycle(4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 16'd8);
      n++;
      if (bank_ret[0]) break;
    end
    check_val("ret_latency", n, 16);

    // request to a retained bank: hold for WAKE_CYC+1 cycles
    h = 0;
    run_cycle(4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 16'd8);
    h += int'(obs[16]);
    for (int k = 0; k < 5; k++) begin
      run_cycle(4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 16'd8);
      h += int'(obs[16]);
    end
    check_val("hold_cycles", h, 3);
    check_val("wake_to_active", {30'd0, bank_state[1:0]}, 0);

    // request on the cycle the count would hit threshold restarts the count
    do_reset();
    repeat (7) run_cycle(4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 16'd8);
    run_cycle(4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 16'd8);
    check_val("req_keeps_active", {30'd0, bank_state[1:0]}, 0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      run_cycle(4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 16'd8);
      n++;
      if (bank_state[1:0] == 2'b01) break;
    end
    check_val("cnt_cleared", n, 8);

    // all banks retained, then a request on bank2 only
    do_reset();
    n = 0;
    for (int k = 0; k < 100; k++) begin
      run_cycle(4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 16'd8);
      n++;
      if (all_ret) break;
    end
    check_val("all_ret_latency", n, 24);
    run_cycle(4'hF, 4'h4, 4'h4, 4'hF, 4'hF, 16'd8);
    check_val("all_ret_drop", {31'd0, all_ret}, 0);
    check_val("bank2_wakes", {24'd0, bank_state}, 32'h0000_00BA);

    // reset mid-WAKE aborts to ACTIVE without a clock edge
    do_reset();
    for (int k = 0; k < 20; k++) begin
      run_cycle(4'hF, 4'h0, 4'h0, 4'h2, 4'h0, 16'd3);
      if (bank_state[3:2] == 2'b01) break;
    end
    check_val("bank1_cg", {30'd0, bank_state[3:2]}, 1);
    run_cycle(4'hF, 4'h2, 4'h2, 4'h2, 4'h0, 16'd3);
    check_val("bank1_wake", {30'd0, bank_state[3:2]}, 3);
    rst_n = 1'b0;
    #1;
    check_val("async_abort", {24'd0, bank_state}, 0);
    run_cycle(4'hF, 4'h2, 4'h2, 4'h2, 4'h0, 16'd3);
    rst_n = 1'b1;

    // idle_thresh = 0: nothing leaves ACTIVE
    for (int k = 0; k < 100; k++)
      run_cycle(rbits(95), 4'h0, 4'h0, rbits(90), rbits(50), 16'd0);
    check_val("thresh0_active", {24'd0, bank_state}, 0);

    // random traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        run_cycle(rbits(50), rbits(50), rbits(50), rbits(50), rbits(50), 16'd2);
        rst_n = 1'b1;
      end else begin
        run_cycle(rbits(92), rbits(8), rbits(70), rbits(93), rbits(80),
                  16'($urandom_range(5)));
      end
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
